// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_if
//  Description : SPI slave front end. Deserialises MOSI frames into command
//                words for the RAM and serialises read data back on MISO.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_if #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int c_FRAME_W = DATA_W + 2;
    localparam int c_RXCNT_W = $clog2(c_FRAME_W);
    localparam int c_TXCNT_W = $clog2(DATA_W);

    localparam logic [c_RXCNT_W-1:0] c_RX_LAST = c_RXCNT_W'(c_FRAME_W - 1);
    localparam logic [c_TXCNT_W-1:0] c_TX_LAST = c_TXCNT_W'(DATA_W - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_CHK_CMD   = 3'd1;
    localparam logic [2:0] c_WRITE     = 3'd2;
    localparam logic [2:0] c_READ_ADD  = 3'd3;
    localparam logic [2:0] c_READ_DATA = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;

    logic [c_RXCNT_W-1:0]  r_bit_cnt;
    logic                  r_frame_done;
    logic [c_FRAME_W-2:0]  r_shift;
    logic [c_FRAME_W-1:0]  r_rx_data;
    logic                  r_rx_valid;
    logic                  r_rd_addr_seen;

    logic [DATA_W-1:0]     r_tx_reg;
    logic [c_TXCNT_W-1:0]  r_tx_cnt;
    logic                  r_tx_armed;
    logic                  r_miso;

    logic                  w_in_frame;
    logic                  w_abort;
    logic                  w_shift_en;
    logic                  w_frame_end;
    logic                  w_set_seen;
    logic                  w_clr_seen;
    logic                  w_tx_arm;
    logic                  w_tx_load;
    logic [c_FRAME_W-1:0]  w_word;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (!SS_n) begin
                    w_next_state = c_CHK_CMD;
                end
            end
            c_CHK_CMD: begin
                if (SS_n) begin
                    w_next_state = c_IDLE;
                end else if (!MOSI) begin
                    w_next_state = c_WRITE;
                end else if (r_rd_addr_seen) begin
                    w_next_state = c_READ_DATA;
                end else begin
                    w_next_state = c_READ_ADD;
                end
            end
            c_WRITE, c_READ_ADD, c_READ_DATA: begin
                if (SS_n) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_in_frame  = (r_state == c_WRITE) || (r_state == c_READ_ADD) ||
                      (r_state == c_READ_DATA);
        // Deselect wins over every other action, including the 10th bit.
        w_abort     = (r_state != c_IDLE) && SS_n;
        w_shift_en  = w_in_frame && !SS_n && !r_frame_done;
        w_frame_end = w_shift_en && (r_bit_cnt == c_RX_LAST);
        w_set_seen  = w_frame_end && (r_state == c_READ_ADD);
        w_clr_seen  = w_frame_end && (r_state == c_READ_DATA);
        w_tx_arm    = w_frame_end && (r_state == c_READ_DATA);
        w_tx_load   = (r_state == c_READ_DATA) && !SS_n && r_tx_armed && tx_valid;
        w_word      = {r_shift, MOSI};
    end

    // ------------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_shift      <= '0;
        end else if (w_abort) begin
            r_bit_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_shift      <= '0;
        end else if (w_shift_en) begin
            r_shift <= w_word[c_FRAME_W-2:0];
            if (w_frame_end) begin
                r_bit_cnt    <= '0;
                r_frame_done <= 1'b1;
            end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= w_frame_end;
            if (w_frame_end) begin
                r_rx_data <= w_word;
            end
        end
    end

    // Survives deselect so a read-address frame pairs with the next read frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr_seen <= 1'b0;
        end else if (w_set_seen) begin
            r_rd_addr_seen <= 1'b1;
        end else if (w_clr_seen) begin
            r_rd_addr_seen <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Transmit path: MSB goes out on the capture edge itself
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_reg   <= '0;
            r_tx_cnt   <= '0;
            r_tx_armed <= 1'b0;
            r_miso     <= 1'b0;
        end else if (w_abort) begin
            r_tx_reg   <= '0;
            r_tx_cnt   <= '0;
            r_tx_armed <= 1'b0;
            r_miso     <= 1'b0;
        end else if (w_tx_load) begin
            r_miso     <= tx_data[DATA_W-1];
            r_tx_reg   <= {tx_data[DATA_W-2:0], 1'b0};
            r_tx_cnt   <= c_TX_LAST;
            r_tx_armed <= 1'b0;
        end else begin
            if (w_tx_arm) begin
                r_tx_armed <= 1'b1;
            end
            if (r_tx_cnt != '0) begin
                r_miso   <= r_tx_reg[DATA_W-1];
                r_tx_reg <= {r_tx_reg[DATA_W-2:0], 1'b0};
                r_tx_cnt <= r_tx_cnt - 1'b1;
            end else begin
                r_miso <= 1'b0;
            end
        end
    end

    assign MISO     = r_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule
`default_nettype wire

// File: doc/spi_slave_if.md
# spi_slave_if

Serial front end of the SPI-slave / single-port-RAM subsystem. It deserialises MOSI frames into 10-bit command words for the RAM (`rx_data`/`rx_valid`). On read-data commands it captures the RAM's 8-bit response (`tx_data`/`tx_valid`) and serialises it back on MISO. One clock domain; the SPI master shifts one bit per `clk` cycle.

## Interface
- `DATA_W`, 8, RAM data width; command word is `DATA_W+2` bits.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `SS_n`  in  1  slave select, active low; frames are delimited by it.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first; registered.
- `rx_data`  out  `DATA_W+2`  assembled command word to the RAM: [9:8] opcode, [7:0] payload.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` is valid while it is high.
- `tx_data`  in  `DATA_W`  read data from the RAM.
- `tx_valid`  in  1  `tx_data` valid strobe from the RAM.

## Operation
- Opcodes in `rx_data[9:8]`:
  - 00 = write address.
  - 01 = write data.
  - 10 = read address.
  - 11 = read data.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: stays while `SS_n`=1. `SS_n`=0 moves to CHK_CMD.
- CHK_CMD: the sampled MOSI bit is the mode bit and is not stored.
  - MOSI=0 goes to WRITE.
  - MOSI=1 with `rd_addr_seen`=0 goes to READ_ADD.
  - MOSI=1 with `rd_addr_seen`=1 goes to READ_DATA.
- WRITE, READ_ADD, READ_DATA: the next 10 MOSI bits shift MSB first into an internal shift register.
  - A 4-bit counter counts 0..9.
  - After the 10th bit, the register loads into `rx_data` and `rx_valid`=1 for exactly one cycle.
- `rx_data` holds its value until the next complete frame. Partial frames never update it.
- READ_ADD sets `rd_addr_seen` on its `rx_valid`. READ_DATA clears it on its `rx_valid`. Only `rst_n` otherwise touches it.
- Bits after the 10th in WRITE or READ_ADD are ignored until `SS_n` rises.
- READ_DATA, after `rx_valid`: waits for `tx_valid`=1.
  - On that edge `tx_data` is captured into an 8-bit output register.
  - MISO then drives bits 7..0 on 8 consecutive cycles, then 0.
  - `tx_valid` is ignored at all other times.
- `SS_n`=1 sampled in any non-IDLE state: next state is IDLE.
  - Counters and the output register clear, MISO=0.
  - The partial frame is discarded with no `rx_valid`.
  - `rd_addr_seen` is retained.
- Reset values: state IDLE, `rx_data`=0, `rx_valid`=0, MISO=0, `rd_addr_seen`=0, counters 0.

## Timing
- Edge numbering: let edge 0 be the first rising edge sampling `SS_n`=0.
- Edge 1 samples the mode bit.
- Edges 2..11 sample `rx_data` bits 9..0.
- `rx_valid` is high in the cycle after edge 11 (sampled at edge 12). `rx_valid` latency from the last MOSI bit is 1 cycle.
- RAM contract: `tx_valid` is high in the cycle after `rx_valid` (sampled at edge 13).
- MISO carries bit 7 after edge 13 and bit 0 after edge 20. The master may raise `SS_n` from edge 21.
- Minimum frame length: 12 cycles for write and read-address, 21 cycles for read-data.
- If `tx_valid` does not arrive, READ_DATA waits indefinitely until `SS_n`=1.
- `SS_n` rising on the same edge as the 10th bit: abort takes priority, so no `rx_valid` is issued.
- Asynchronous reset mid-frame clears all state immediately. No strobe is emitted.
- Back-to-back frames: `SS_n` high for at least 1 cycle between them (one IDLE cycle).

## Test plan
- Write address: `SS_n`↓, MOSI 0 then 00_1010_0101 → `rx_data`=10'h0A5 and `rx_valid`=1 for one cycle at edge 12; MISO stays 0.
- Write data: mode 0, then 01_0011_1100 → `rx_data`=10'h13C, single `rx_valid` pulse; `rd_addr_seen` unchanged at 0.
- Read sequence, first frame: mode 1, 10_1010_0101 → `rx_data`=10'h2A5, FSM in READ_ADD.
- Read sequence, second frame: mode 1, 11_0000_0000 → `rx_data`=10'h300. Bench returns `tx_valid` with `tx_data`=8'hC3 at edge 13 → MISO=1,1,0,0,0,0,1,1 over edges 14..21, then 0.
- Abort: `SS_n`↑ after 5 payload bits → no `rx_valid`, `rx_data` keeps its old value. The next full write frame 10'h055 is received correctly.
- Reset and ordering: `rst_n` pulsed low mid read-address frame → all outputs 0 and `rd_addr_seen`=0. A following mode-1 frame enters READ_ADD, not READ_DATA. A read-data frame with no `tx_valid` keeps MISO=0 until `SS_n`↑.
